// File: rtl/conv_soft_encoder.sv
// Rate-1/2 convolutional encoder emitting signed I/Q soft symbols over a valid/ready handshake.
// Optional feature macro CONV_TAIL_EN: flush K-1 zero tail bits after each frame's last bit.
module conv_soft_encoder #(
    parameter int unsigned  K      = 7,
    parameter logic [K-1:0] G1     = 7'h79,
    parameter logic [K-1:0] G2     = 7'h5B,
    parameter int unsigned  SOFT_W = 8
) (
    input  logic                     clk,
    input  logic                     sys_rst_n,
    input  logic                     bit_in,
    input  logic                     valid_in,
    input  logic                     last_in,
    input  logic                     invert_q,
    output logic                     ready_in,
    output logic signed [SOFT_W-1:0] soft_out,
    output logic                     valid_out,
    input  logic                     ready_out,
    output logic                     sym_q,
    output logic                     last_out,
    output logic [K-2:0]             state_out,
    output logic [15:0]              frame_bits
);
    localparam int unsigned SW   = K - 1;
    localparam int unsigned FB_W = 16;
    localparam logic [SOFT_W-1:0] SOFT_ONE  = {1'b0, {(SOFT_W-1){1'b1}}};
    localparam logic [SOFT_W-1:0] SOFT_ZERO = {1'b1, {(SOFT_W-1){1'b0}}};

`ifdef CONV_TAIL_EN
    localparam int unsigned CNT_W = $clog2(K);
    typedef enum logic [2:0] {ST_IDLE, ST_SYM_I, ST_SYM_Q, ST_TAIL_I, ST_TAIL_Q} fsm_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SYM_I, ST_SYM_Q} fsm_e;
`endif

    function automatic logic [1:0] encode(input logic b, input logic [SW-1:0] st);
        logic [K-1:0] word;
        word = {b, st};
        return {^(word & G1), ^(word & G2)};
    endfunction

    function automatic logic [SW-1:0] next_state(input logic b, input logic [SW-1:0] st);
        return SW'({b, st} >> 1);
    endfunction

    function automatic logic [SOFT_W-1:0] smap(input logic b);
        return b ? SOFT_ONE : SOFT_ZERO;
    endfunction

    fsm_e              fsm_q, fsm_d;
    logic [SW-1:0]     enc_q, enc_d;
    logic [SOFT_W-1:0] soft_q, soft_d;
    logic              symq_q, symq_d;
    logic              last_q, last_d;
    logic              qbit_q, qbit_d;
    logic              lastbit_q, lastbit_d;
    logic              inv_q, inv_d;
    logic              first_q, first_d;
    logic [FB_W-1:0]   fb_q, fb_d;

    logic [1:0]        enc_c;
    logic              inv_eff_c;
    logic              tail_pend_c;
    logic              accept_c;
    logic              out_xfer_c;
    logic [FB_W-1:0]   fb_base_c;

`ifdef CONV_TAIL_EN
    logic [CNT_W-1:0]  tail_cnt_q, tail_cnt_d;
    logic [1:0]        enc_t_c;
    assign enc_t_c     = encode(1'b0, enc_q);
    assign tail_pend_c = lastbit_q;
`else
    assign tail_pend_c = 1'b0;
`endif

    assign enc_c      = encode(bit_in, enc_q);
    assign inv_eff_c  = first_q ? invert_q : inv_q;
    assign ready_in   = (fsm_q == ST_IDLE) || ((fsm_q == ST_SYM_Q) && ready_out && !tail_pend_c);
    assign accept_c   = valid_in && ready_in;
    assign valid_out  = (fsm_q != ST_IDLE);
    assign out_xfer_c = valid_out && ready_out;
    // Frame count restarts when the frame's final symbol leaves, even if a new bit lands that cycle.
    assign fb_base_c  = (out_xfer_c && last_q) ? '0 : fb_q;

    // Next-state and symbol sequencing
    always_comb begin
        fsm_d     = fsm_q;
        enc_d     = enc_q;
        soft_d    = soft_q;
        symq_d    = symq_q;
        last_d    = last_q;
        qbit_d    = qbit_q;
        lastbit_d = lastbit_q;
        inv_d     = inv_q;
        first_d   = first_q;
        fb_d      = fb_base_c;
`ifdef CONV_TAIL_EN
        tail_cnt_d = tail_cnt_q;
`endif
        case (fsm_q)
            ST_IDLE: ;
            ST_SYM_I: begin
                if (ready_out) begin
                    soft_d = smap(qbit_q);
                    symq_d = 1'b1;
`ifdef CONV_TAIL_EN
                    last_d = 1'b0;
`else
                    last_d = lastbit_q;
`endif
                    fsm_d  = ST_SYM_Q;
                end
            end
            ST_SYM_Q: begin
                if (ready_out) begin
                    fsm_d  = ST_IDLE;
                    symq_d = 1'b0;
                    last_d = 1'b0;
`ifdef CONV_TAIL_EN
                    if (lastbit_q) begin
                        fsm_d      = ST_TAIL_I;
                        tail_cnt_d = CNT_W'(K - 2);
                        soft_d     = smap(enc_t_c[1]);
                        qbit_d     = enc_t_c[0] ^ inv_q;
                        enc_d      = next_state(1'b0, enc_q);
                        lastbit_d  = 1'b0;
                    end
`endif
                end
            end
`ifdef CONV_TAIL_EN
            ST_TAIL_I: begin
                if (ready_out) begin
                    soft_d = smap(qbit_q);
                    symq_d = 1'b1;
                    last_d = (tail_cnt_q == '0);
                    fsm_d  = ST_TAIL_Q;
                end
            end
            ST_TAIL_Q: begin
                if (ready_out) begin
                    symq_d = 1'b0;
                    last_d = 1'b0;
                    if (tail_cnt_q == '0) begin
                        fsm_d = ST_IDLE;
                    end else begin
                        fsm_d      = ST_TAIL_I;
                        tail_cnt_d = tail_cnt_q - CNT_W'(1);
                        soft_d     = smap(enc_t_c[1]);
                        qbit_d     = enc_t_c[0] ^ inv_q;
                        enc_d      = next_state(1'b0, enc_q);
                    end
                end
            end
`endif
            default: fsm_d = ST_IDLE;
        endcase

        // A new bit overrides the idle/Q-done outcome; both symbols are computed now.
        if (accept_c) begin
            fsm_d     = ST_SYM_I;
            soft_d    = smap(enc_c[1]);
            symq_d    = 1'b0;
            last_d    = 1'b0;
            qbit_d    = enc_c[0] ^ inv_eff_c;
            enc_d     = next_state(bit_in, enc_q);
            inv_d     = inv_eff_c;
            first_d   = last_in;
            lastbit_d = last_in;
            fb_d      = (fb_base_c == '1) ? fb_base_c : fb_base_c + FB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fsm_q     <= ST_IDLE;
            enc_q     <= '0;
            soft_q    <= '0;
            symq_q    <= 1'b0;
            last_q    <= 1'b0;
            qbit_q    <= 1'b0;
            lastbit_q <= 1'b0;
            inv_q     <= 1'b0;
            first_q   <= 1'b1;
            fb_q      <= '0;
`ifdef CONV_TAIL_EN
            tail_cnt_q <= '0;
`endif
        end else begin
            fsm_q     <= fsm_d;
            enc_q     <= enc_d;
            soft_q    <= soft_d;
            symq_q    <= symq_d;
            last_q    <= last_d;
            qbit_q    <= qbit_d;
            lastbit_q <= lastbit_d;
            inv_q     <= inv_d;
            first_q   <= first_d;
            fb_q      <= fb_d;
`ifdef CONV_TAIL_EN
            tail_cnt_q <= tail_cnt_d;
`endif
        end
    end

    assign soft_out   = soft_q;
    assign sym_q      = symq_q;
    assign last_out   = last_q;
    assign state_out  = enc_q;
    assign frame_bits = fb_q;

endmodule

// File: tb/tb_conv_soft_encoder.sv
// Scoreboard bench for conv_soft_encoder: directed vectors plus a reference encoder for the long run.
module tb_conv_soft_encoder;
    localparam int unsigned K      = 7;
    localparam int unsigned SOFT_W = 8;
    localparam logic [K-1:0] G1    = 7'h79;
    localparam logic [K-1:0] G2    = 7'h5B;
    localparam int unsigned NRAND  = 140;

    logic                     clk       = 1'b0;
    logic                     sys_rst_n = 1'b0;
    logic                     bit_in    = 1'b0;
    logic                     valid_in  = 1'b0;
    logic                     last_in   = 1'b0;
    logic                     invert_q  = 1'b0;
    logic                     ready_out = 1'b1;
    logic                     ready_in;
    logic signed [SOFT_W-1:0] soft_out;
    logic                     valid_out;
    logic                     sym_q;
    logic                     last_out;
    logic [K-2:0]             state_out;
    logic [15:0]              frame_bits;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int acc_cyc   = 0;
    int first_acc = 0;

    logic [9:0]   exp_q [$];
    logic [9:0]   mon_e;
    logic [K-2:0] m_state;
    logic         m_inv;
    logic         m_first;
    logic [7:0]   tail_exp [14] = '{8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h7F, 8'h7F, 8'h7F,
                                    8'h7F, 8'h80, 8'h80, 8'h80, 8'h7F, 8'h7F, 8'h7F};

    conv_soft_encoder #(.K(K), .G1(G1), .G2(G2), .SOFT_W(SOFT_W)) dut (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .bit_in     (bit_in),
        .valid_in   (valid_in),
        .last_in    (last_in),
        .invert_q   (invert_q),
        .ready_in   (ready_in),
        .soft_out   (soft_out),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .sym_q      (sym_q),
        .last_out   (last_out),
        .state_out  (state_out),
        .frame_bits (frame_bits)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] smap(input logic b);
        return b ? 8'h7F : 8'h80;
    endfunction

    function automatic logic par_taps(input logic [K-1:0] w, input logic [K-1:0] g);
        logic p;
        p = 1'b0;
        for (int i = 0; i < K; i++)
            if (g[i]) p = p ^ w[i];
        return p;
    endfunction

    task automatic push(input logic [7:0] s, input logic q, input logic l);
        exp_q.push_back({s, q, l});
    endtask

    // Reference encoder: pushes the symbols one accepted bit should produce
    task automatic model_bit(input logic b, input logic l, input logic inv);
        logic [K-1:0] w;
        logic         ie;
        ie = m_first ? inv : m_inv;
        if (m_first) m_inv = inv;
        w = {b, m_state};
        push(smap(par_taps(w, G1)), 1'b0, 1'b0);
`ifdef CONV_TAIL_EN
        push(smap(par_taps(w, G2) ^ ie), 1'b1, 1'b0);
`else
        push(smap(par_taps(w, G2) ^ ie), 1'b1, l);
`endif
        m_state = w[K-1:1];
        m_first = l;
`ifdef CONV_TAIL_EN
        if (l) begin
            for (int t = 0; t < K - 1; t++) begin
                w = {1'b0, m_state};
                push(smap(par_taps(w, G1)), 1'b0, 1'b0);
                push(smap(par_taps(w, G2) ^ m_inv), 1'b1, t == K - 2);
                m_state = w[K-1:1];
            end
        end
`endif
    endtask

    // Must be called just after a rising edge; returns just after the accepting edge
    task automatic send_bit(input logic b, input logic l, input logic inv);
        int waited;
        waited   = 0;
        bit_in   = b;
        last_in  = l;
        invert_q = inv;
        valid_in = 1'b1;
        @(negedge clk);
        while (!ready_in && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!ready_in) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready_in got 0, expected 1 within 200 cycles");
            valid_in = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        valid_in = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 2000) begin
            @(posedge clk);
            w++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        valid_in  = 1'b0;
        bit_in    = 1'b0;
        last_in   = 1'b0;
        invert_q  = 1'b0;
        ready_out = 1'b1;
        sys_rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 sys_rst_n = 1'b1;
    endtask

    // Monitor: compare each transferred symbol against the scoreboard head
    always @(negedge clk) begin
        if (sys_rst_n && valid_out && ready_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_symbol: got soft=0x%0h sym_q=%0b last=%0b, expected none",
                         soft_out, sym_q, last_out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("symbol", 32'({soft_out, sym_q, last_out}), 32'(mon_e));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        logic b, inv;
        do_reset();
        chk("rst_valid_out",  32'(valid_out),  32'd0);
        chk("rst_state_out",  32'(state_out),  32'd0);
        chk("rst_frame_bits", 32'(frame_bits), 32'd0);
        chk("rst_soft_out",   32'(soft_out),   32'd0);
        chk("rst_sym_q",      32'(sym_q),      32'd0);
        chk("rst_last_out",   32'(last_out),   32'd0);
        chk("rst_ready_in",   32'(ready_in),   32'd1);

`ifndef CONV_TAIL_EN
        // Bit 1 then bit 0 from state 0
        push(8'h7F, 1'b0, 1'b0); push(8'h7F, 1'b1, 1'b0);
        push(8'h7F, 1'b0, 1'b0); push(8'h80, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b0);
        chk("fb_after_first", 32'(frame_bits), 32'd1);
        chk("state_after_b1", 32'(state_out),  32'd32);
        send_bit(1'b0, 1'b1, 1'b0);
        chk("state_after_b0", 32'(state_out),  32'd16);
        chk("fb_after_second", 32'(frame_bits), 32'd2);
        drain();
        chk("fb_cleared",     32'(frame_bits), 32'd0);
        chk("state_persists", 32'(state_out),  32'd16);

        // Same bits with Q inverted; invert_q on the second bit must be ignored
        do_reset();
        push(8'h7F, 1'b0, 1'b0); push(8'h80, 1'b1, 1'b0);
        push(8'h7F, 1'b0, 1'b0); push(8'h7F, 1'b1, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b1, 1'b0);
        drain();

        // Downstream stall on the I symbol
        do_reset();
        ready_out = 1'b0;
        push(8'h7F, 1'b0, 1'b0); push(8'h7F, 1'b1, 1'b1);
        send_bit(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid",    32'(valid_out), 32'd1);
            chk("stall_soft",     32'(soft_out),  32'h7F);
            chk("stall_sym_q",    32'(sym_q),     32'd0);
            chk("stall_ready_in", 32'(ready_in),  32'd0);
        end
        @(posedge clk);
        #1 ready_out = 1'b1;
        drain();
        chk("state_after_stall", 32'(state_out), 32'd32);
`else
        // One-bit frame followed by six zero tail bits
        for (int i = 0; i < 14; i++)
            push(tail_exp[i], i[0], i == 13);
        send_bit(1'b1, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        chk("tail_ready_in", 32'(ready_in), 32'd0);
        drain();
        chk("tail_state_out", 32'(state_out),  32'd0);
        chk("tail_fb",        32'(frame_bits), 32'd0);
`endif

        // Reset while a symbol is pending
        ready_out = 1'b0;
        send_bit(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("mid_valid_out", 32'(valid_out), 32'd1);
        @(posedge clk);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("midrst_valid_out",  32'(valid_out),  32'd0);
        chk("midrst_state_out",  32'(state_out),  32'd0);
        chk("midrst_frame_bits", 32'(frame_bits), 32'd0);
        @(posedge clk);
        #1;
        sys_rst_n = 1'b1;
        ready_out = 1'b1;

        // Long back-to-back frame against the reference encoder, starting from state 0
        m_state = '0;
        m_first = 1'b1;
        m_inv   = 1'b0;
        for (int i = 0; i < NRAND; i++) begin
            b   = 1'($urandom);
            inv = (i == 0) ? 1'b1 : 1'($urandom);
            model_bit(b, i == NRAND - 1, inv);
            send_bit(b, i == NRAND - 1, inv);
            if (i == 0) first_acc = acc_cyc;
        end
        chk("throughput_span", 32'(acc_cyc - first_acc), 32'(2 * (NRAND - 1)));
        drain();
        chk("rand_fb_cleared", 32'(frame_bits), 32'd0);
        chk("rand_state", 32'(state_out), 32'(m_state));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
